// File: rtl/tdm_rr_scheduler_if.sv
// tdm_rr_scheduler_if
// Data-path bundle between the per-channel capture stages, the scheduler and
// the single-stream consumer.
//   din        : NUM_CH*WIDTH channel words, channel c at [c*WIDTH +: WIDTH]
//   din_valid  : per-channel write strobe (no ready; full FIFOs drop)
//   dout       : scheduled word
//   dout_ch    : channel tag of dout
//   dout_valid : dout/dout_ch carry a word
//   dout_ready : consumer accepts the word
// Handshake: a word moves on a rising edge where dout_valid and dout_ready
// are both 1; while dout_valid=1 and dout_ready=0 the producer holds dout,
// dout_ch and dout_valid stable; dout_valid never depends combinationally
// on dout_ready.
// Modports: slave = scheduler side, master = upstream/downstream side.
interface tdm_rr_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) ();
  logic [NUM_CH*WIDTH-1:0]   din;
  logic [NUM_CH-1:0]         din_valid;
  logic [WIDTH-1:0]          dout;
  logic [$clog2(NUM_CH)-1:0] dout_ch;
  logic                      dout_valid;
  logic                      dout_ready;

  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_ch, dout_valid
  );

  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_ch, dout_valid
  );
endinterface

// File: rtl/tdm_rr_scheduler.sv
// tdm_rr_scheduler
// N-channel round-robin TDM: each channel is captured into its own FIFO and
// a scheduler serialises the channels onto one tagged valid/ready stream.
// STRICT=0 skips empty channels (work-conserving); STRICT=1 walks a fixed
// slot rotation and emits idle slots for empty channels.
// Optional feature macro: TDM_DROP_CNT_EN adds per-channel saturating drop
// counters on the drop_cnt port (port absent when the macro is undefined).
// Ports:
//   clk       : sole clock
//   rst       : asynchronous active-low reset
//   bus       : tdm_rr_scheduler_if.slave (din/din_valid in, dout stream out)
//   fifo_full : per-channel FIFO full, registered
//   overflow  : sticky per-channel drop flags
//   ovf_clr   : clears overflow (and drop counters); a same-edge drop wins
//   drop_cnt  : per-channel drop counters (TDM_DROP_CNT_EN only)
//   ptr       : scheduler pointer, exposed for observation
module tdm_rr_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STRICT     = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  tdm_rr_scheduler_if.slave           bus,
  output logic [NUM_CH-1:0]           fifo_full,
  output logic [NUM_CH-1:0]           overflow,
  input  logic                        ovf_clr,
`ifdef TDM_DROP_CNT_EN
  output logic [NUM_CH*CNT_WIDTH-1:0] drop_cnt,
`endif
  output logic [$clog2(NUM_CH)-1:0]   ptr
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  if (NUM_CH < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      CNT_WIDTH < 1) begin : g_param_check
    $error("tdm_rr_scheduler: illegal parameter set");
  end

  // Explicit wrap so non-power-of-two NUM_CH goes NUM_CH-1 -> 0.
  function automatic logic [CW-1:0] inc_ch(input logic [CW-1:0] c);
    return (c == LAST_CH) ? '0 : c + CW'(1);
  endfunction

  logic [WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr [NUM_CH];
  logic [AW-1:0]    rd_ptr [NUM_CH];
  logic [AW:0]      count [NUM_CH];
  logic [AW:0]      count_next [NUM_CH];

  logic [NUM_CH-1:0] nonempty, push, pop, drop;
  logic              free, found;
  logic [CW-1:0]     sel, cand;
  logic [WIDTH-1:0]  head;

  assign free = !bus.dout_valid || bus.dout_ready;
  assign head = mem[sel][rd_ptr[sel]];

  // Channel selection. Only registered FIFO state is looked at, so a word
  // written this edge cannot be popped until the next one (no bypass).
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = ptr;
    for (int c = 0; c < NUM_CH; c++) nonempty[c] = (count[c] != '0);
    if (STRICT != 0) begin
      found = nonempty[ptr];
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && nonempty[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
        cand = inc_ch(cand);
      end
    end
  end

  // A full FIFO still accepts a write when it is popped on the same edge.
  always_comb begin
    pop = '0;
    if (free && found) pop[sel] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      push[c] = bus.din_valid[c] && ((count[c] != DEPTH_C) || pop[c]);
      drop[c] = bus.din_valid[c] && !push[c];
      case ({push[c], pop[c]})
        2'b10:   count_next[c] = count[c] + (AW+1)'(1);
        2'b01:   count_next[c] = count[c] - (AW+1)'(1);
        default: count_next[c] = count[c];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= bus.din[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      fifo_full <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
        count[c]     <= count_next[c];
        fifo_full[c] <= (count_next[c] == DEPTH_C);
      end
    end
  end

  // Output register and pointer. Strict mode advances one slot per free
  // edge and keeps dout on idle slots; work-conserving mode moves the
  // pointer past the served channel and holds it when nothing is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dout       <= '0;
      bus.dout_ch    <= '0;
      bus.dout_valid <= 1'b0;
      ptr            <= '0;
    end else if (free) begin
      if (STRICT != 0) begin
        bus.dout_ch    <= ptr;
        bus.dout_valid <= found;
        if (found) bus.dout <= head;
        ptr <= inc_ch(ptr);
      end else if (found) begin
        bus.dout       <= head;
        bus.dout_ch    <= sel;
        bus.dout_valid <= 1'b1;
        ptr            <= inc_ch(sel);
      end else begin
        bus.dout_valid <= 1'b0;
      end
    end
  end

  // Clear first, then OR in this edge's drops so a simultaneous drop wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= '0;
    else      overflow <= (ovf_clr ? '0 : overflow) | drop;
  end

`ifdef TDM_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (drop[c]) begin
          if (ovf_clr)              cnt_q[c] <= CNT_WIDTH'(1);
          else if (cnt_q[c] != '1)  cnt_q[c] <= cnt_q[c] + CNT_WIDTH'(1);
        end else if (ovf_clr) begin
          cnt_q[c] <= '0;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt_out
    assign drop_cnt[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
  end
`endif

endmodule

// File: tb/tb_tdm_rr_scheduler.sv
// tb_tdm_rr_scheduler
// Directed bench for tdm_rr_scheduler: one work-conserving instance (u_wc)
// fed through a scoreboard queue, one strict-slot instance (u_st) checked
// slot by slot against a hand-derived table.
module tb_tdm_rr_scheduler;

  localparam int NUM_CH    = 4;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 8;
  localparam int CW        = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic ovf_clr;
  always #5 clk = ~clk;

  tdm_rr_scheduler_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) wc_if ();
  tdm_rr_scheduler_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) st_if ();

  logic [NUM_CH-1:0] wc_full, wc_ovf, st_full, st_ovf;
  logic [CW-1:0]     wc_ptr, st_ptr;
`ifdef TDM_DROP_CNT_EN
  logic [NUM_CH*CNT_WIDTH-1:0] wc_drop_cnt, st_drop_cnt;
`endif

  tdm_rr_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH),
                     .STRICT(0), .CNT_WIDTH(CNT_WIDTH)) u_wc (
    .clk       (clk),
    .rst       (rst),
    .bus       (wc_if),
    .fifo_full (wc_full),
    .overflow  (wc_ovf),
    .ovf_clr   (ovf_clr),
`ifdef TDM_DROP_CNT_EN
    .drop_cnt  (wc_drop_cnt),
`endif
    .ptr       (wc_ptr)
  );

  tdm_rr_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH),
                     .STRICT(1), .CNT_WIDTH(CNT_WIDTH)) u_st (
    .clk       (clk),
    .rst       (rst),
    .bus       (st_if),
    .fifo_full (st_full),
    .overflow  (st_ovf),
    .ovf_clr   (ovf_clr),
`ifdef TDM_DROP_CNT_EN
    .drop_cnt  (st_drop_cnt),
`endif
    .ptr       (st_ptr)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CW+WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a transfer happens on the next rising edge whenever
  // valid and ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && wc_if.dout_valid === 1'b1 && wc_if.dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wc_spurious_word", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [CW+WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("wc_word", 64'({wc_if.dout_ch, wc_if.dout}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wc_put(input int ch, input logic [WIDTH-1:0] d);
    wc_if.din[ch*WIDTH +: WIDTH] = d;
    wc_if.din_valid[ch] = 1'b1;
  endtask

  task automatic st_put(input int ch, input logic [WIDTH-1:0] d);
    st_if.din[ch*WIDTH +: WIDTH] = d;
    st_if.din_valid[ch] = 1'b1;
  endtask

  task automatic expect_word(input int ch, input logic [WIDTH-1:0] d);
    exp_q.push_back({CW'(ch), d});
  endtask

  // Strict-slot expectations after each edge following reset release.
  logic           st_exp_valid [1:12] = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1};
  logic [WIDTH-1:0] st_exp_dout [1:12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20,
                                          8'h20, 8'h30, 8'h11, 8'h21, 8'h21, 8'h31};

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    ovf_clr = 1'b0;
    wc_if.din = '0; wc_if.din_valid = '0; wc_if.dout_ready = 1'b0;
    st_if.din = '0; st_if.din_valid = '0; st_if.dout_ready = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_valid", 64'(wc_if.dout_valid), 64'd0);
    check("rst_dout", 64'({wc_if.dout_ch, wc_if.dout}), 64'd0);
    check("rst_ptr", 64'(wc_ptr), 64'd0);
    check("rst_flags", 64'({wc_full, wc_ovf}), 64'd0);

    // Idle for 20 cycles
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_valid", 64'(wc_if.dout_valid), 64'd0);
      check("idle_ptr", 64'(wc_ptr), 64'd0);
      check("idle_flags", 64'({wc_full, wc_ovf}), 64'd0);
    end

    // Latency and tagging: write at edge k, visible after k+1 for one cycle
    wc_if.dout_ready = 1'b1;
    wc_put(2, 8'h5A);
    expect_word(2, 8'h5A);
    step();
    wc_if.din_valid = '0;
    check("lat_k_valid", 64'(wc_if.dout_valid), 64'd0);
    step();
    check("lat_k1_valid", 64'(wc_if.dout_valid), 64'd1);
    check("lat_k1_dout", 64'(wc_if.dout), 64'h5A);
    check("lat_k1_ch", 64'(wc_if.dout_ch), 64'd2);
    check("lat_k1_ptr", 64'(wc_ptr), 64'd3);
    step();
    check("lat_one_cycle", 64'(wc_if.dout_valid), 64'd0);

    // Reset pulse brings ptr back to 0
    rst = 1'b0;
    step();
    check("pulse_ptr", 64'(wc_ptr), 64'd0);
    rst = 1'b1;

    // Work-conserving fairness
    expect_word(0, 8'h10); expect_word(1, 8'h20); expect_word(3, 8'h30);
    expect_word(0, 8'h11); expect_word(1, 8'h21); expect_word(3, 8'h31);
    wc_put(0, 8'h10); wc_put(1, 8'h20); wc_put(3, 8'h30);
    step();
    check("fair_first_edge_idle", 64'(wc_if.dout_valid), 64'd0);
    wc_put(0, 8'h11); wc_put(1, 8'h21); wc_put(3, 8'h31);
    step();
    wc_if.din_valid = '0;
    check("fair_valid", 64'(wc_if.dout_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("fair_valid", 64'(wc_if.dout_valid), 64'd1);
    end
    step();
    check("fair_drained", 64'(wc_if.dout_valid), 64'd0);
    check("fair_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure and overflow: 6 writes, 1 held + 4 buffered + 1 dropped
    wc_if.dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wc_put(0, 8'hA0 + 8'(i));
      step();
      if (i == 3) check("bp_not_full_yet", 64'(wc_full), 64'd0);
    end
    wc_if.din_valid = '0;
    check("bp_held_valid", 64'(wc_if.dout_valid), 64'd1);
    check("bp_held_dout", 64'(wc_if.dout), 64'hA0);
    check("bp_full", 64'(wc_full), 64'd1);
    check("bp_overflow", 64'(wc_ovf), 64'd1);
`ifdef TDM_DROP_CNT_EN
    check("bp_drop_cnt", 64'(wc_drop_cnt[0 +: CNT_WIDTH]), 64'd1);
`endif
    for (int i = 0; i < 5; i++) expect_word(0, 8'hA0 + 8'(i));
    wc_if.dout_ready = 1'b1;
    step();
    check("bp_full_released", 64'(wc_full), 64'd0);
    repeat (6) step();
    check("bp_drained", 64'(wc_if.dout_valid), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // ovf_clr alone clears
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_overflow", 64'(wc_ovf), 64'd0);
`ifdef TDM_DROP_CNT_EN
    check("clr_drop_cnt", 64'(wc_drop_cnt[0 +: CNT_WIDTH]), 64'd0);
`endif

    // Refill channel 0 to full behind a stalled output
    wc_if.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wc_put(0, 8'hB0 + 8'(i));
      step();
    end
    check("refill_full", 64'(wc_full), 64'd1);
    check("refill_no_ovf", 64'(wc_ovf), 64'd0);
    wc_put(0, 8'hB5);
    step();
    check("drop_sets_ovf", 64'(wc_ovf), 64'd1);
`ifdef TDM_DROP_CNT_EN
    check("drop_cnt_one", 64'(wc_drop_cnt[0 +: CNT_WIDTH]), 64'd1);
`endif
    // Clear together with a new drop: set wins, counter restarts at 1
    wc_put(0, 8'hB6);
    ovf_clr = 1'b1;
    step();
    check("clr_vs_set_ovf", 64'(wc_ovf), 64'd1);
`ifdef TDM_DROP_CNT_EN
    check("clr_vs_inc_cnt", 64'(wc_drop_cnt[0 +: CNT_WIDTH]), 64'd1);
`endif
    wc_if.din_valid = '0;
    step();
    ovf_clr = 1'b0;
    check("clr_again_ovf", 64'(wc_ovf), 64'd0);

    // Reset mid-burst: two words leave, then reset discards the rest
    expect_word(0, 8'hB0); expect_word(0, 8'hB1);
    wc_if.dout_ready = 1'b1;
    step();
    step();
    check("burst_dout_before_rst", 64'(wc_if.dout), 64'hB2);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(wc_if.dout_valid), 64'd0);
    check("mid_rst_full", 64'(wc_full), 64'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_no_stale", 64'(wc_if.dout_valid), 64'd0);
    end
    check("burst_queue_empty", 64'(exp_q.size()), 64'd0);

    // Strict slots: writes timed so the first populated slot is channel 0
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      st_if.din_valid = '0;
      case (k)
        1: st_put(0, 8'h10);
        2: begin st_put(0, 8'h11); st_put(1, 8'h20); end
        3: st_put(1, 8'h21);
        4: st_put(3, 8'h30);
        5: st_put(3, 8'h31);
        default: ;
      endcase
      step();
      check("st_valid", 64'(st_if.dout_valid), 64'(st_exp_valid[k]));
      check("st_ch", 64'(st_if.dout_ch), 64'((k - 1) % NUM_CH));
      check("st_dout", 64'(st_if.dout), 64'(st_exp_dout[k]));
      check("st_ptr", 64'(st_ptr), 64'(k % NUM_CH));
    end
    st_if.din_valid = '0;
    step();
    check("st_rotation_idle", 64'(st_if.dout_valid), 64'd0);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_rr_scheduler.md
# tdm_rr_scheduler

Parametrised N-channel round-robin time-division multiplexer with per-channel input buffering and a valid/ready output. Each channel is captured into its own small FIFO, and a scheduler serialises the channels onto one tagged output stream. It sits between the per-channel capture/buffer stages and the single-stream DSP path, for example the multiplier that follows. It supersedes the fixed two-input, free-running round-robin mux by adding channel tags, back-pressure, overflow detection, and a choice between work-conserving and strict-slot scheduling.

## Interface
- NUM_CH, 4: number of input channels, ≥2.
- WIDTH, 8: data width per channel.
- FIFO_DEPTH, 4: per-channel FIFO depth, a power of two ≥2.
- STRICT, 0: 0 = work-conserving (skip empty channels); 1 = strict slot (fixed rotation, idle slots emitted).
- CNT_WIDTH, 8: drop-counter width; used only with the macro.
- clk, input, 1: sole clock.
- rst, input, 1: asynchronous, active-low reset.
- din, input, NUM_CH*WIDTH: channel data; channel c occupies bits [c*WIDTH +: WIDTH].
- din_valid, input, NUM_CH: per-channel write strobe.
- dout, output, WIDTH: scheduled data word.
- dout_ch, output, $clog2(NUM_CH): channel tag of dout.
- dout_valid, output, 1: dout/dout_ch hold a valid word.
- dout_ready, input, 1: downstream accepts the word.
- fifo_full, output, NUM_CH: per-channel FIFO full.
- overflow, output, NUM_CH: sticky per-channel drop flag.
- ovf_clr, input, 1: clears all overflow flags.
- drop_cnt, output, NUM_CH*CNT_WIDTH: per-channel drop counters. Present only with TDM_DROP_CNT_EN.

## Operation
- **Reset** (rst low, async): all FIFOs are emptied and the pointer ptr goes to 0. dout, dout_ch, dout_valid, overflow, and drop_cnt all go to 0. fifo_full goes to 0. Asserting reset mid-operation discards all buffered and in-flight words.
- **Write**: on a rising edge with din_valid[c]=1, the word is pushed if count[c] < FIFO_DEPTH, or if channel c is popped on the same edge.
  - Otherwise the word is dropped and overflow[c] is set.
  - fifo_full[c] = (count[c] == FIFO_DEPTH), registered.
- **Output stage**: a single register. It is "free" when dout_valid=0 or dout_ready=1.
  - A transfer occurs on an edge where dout_valid & dout_ready are both 1.
  - While not free, dout and dout_ch are held stable.
- **Work-conserving scheduling (STRICT=0)**: when free, select the first non-empty channel s searching ptr, ptr+1, … mod NUM_CH.
  - Pop s, load dout and dout_ch=s, set dout_valid=1, and set ptr=(s+1) mod NUM_CH.
  - If all channels are empty, set dout_valid=0 and leave ptr unchanged.
- **Strict-slot scheduling (STRICT=1)**: when free, the slot channel is ptr, and ptr advances by 1 mod NUM_CH on every free edge.
  - If FIFO[ptr] is non-empty: pop it, set dout_valid=1, dout_ch=ptr.
  - Else: set dout_valid=0, dout_ch=ptr, dout unchanged.
- **Wrap-around**: ptr goes NUM_CH-1 → 0, including for non-power-of-two NUM_CH.
- **ovf_clr**: clears all overflow bits on the edge. If a drop occurs on channel c in the same cycle, set wins for that bit.
- **Arithmetic**: FIFO pointers are $clog2(FIFO_DEPTH) wide and wrap naturally. count is $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- **Latency**: a word written on edge k into an empty system appears with dout_valid=1 after edge k+1 (2-cycle latency). There is no combinational bypass from din to dout.
- **Throughput**: one word per cycle while dout_ready=1 and data is available.
- **Strict mode**: exactly one slot per free cycle. With dout_ready held at 1, a full rotation takes NUM_CH cycles.
- **Push/pop on the same FIFO and same edge**: count is unchanged, and the FIFO stays full if it was full.
- **No combinational paths** from inputs to outputs. All outputs are registered.

## Configuration
- Macro: TDM_DROP_CNT_EN.
- **Defined**: per-channel saturating counters of dropped words.
  - Each counter increments on every drop and saturates at 2^CNT_WIDTH-1.
  - ovf_clr also clears the counters; an increment on the same edge wins and yields 1.
  - drop_cnt is reset to 0.
- **Undefined**: no counters are built and the drop_cnt port is absent. The overflow flags are still present.

## Test plan
- **Reset and idle**: NUM_CH=4, STRICT=0. Release rst with no input → dout_valid=0, ptr=0, all flags 0, for 20 cycles.
- **Latency and tagging**: write 0x5A on channel 2 at edge k, with dout_ready=1 → dout=0x5A, dout_ch=2, dout_valid=1 after edge k+1, and only for that one cycle.
- **Work-conserving fairness**: preload channels 0, 1, 3 with {0x10,0x11}, {0x20,0x21}, {0x30,0x31}; dout_ready=1 → output order 0x10, 0x20, 0x30, 0x11, 0x21, 0x31, with no idle cycles.
- **Strict slots**: STRICT=1, same preload → channel tags 0, 1, 2(invalid), 3, 0, 1, 2(invalid), 3. Data as above; dout_valid=0 on channel-2 slots.
- **Back-pressure and overflow**: dout_ready=0, write 6 words to channel 0 with FIFO_DEPTH=4.
  - Expected: 1 word in the output register plus 4 buffered; fifo_full[0]=1; 1 word dropped; overflow[0]=1; drop_cnt[0]=1 if the macro is defined.
  - Then release dout_ready → 5 words in order.
- **Clear vs set and reset mid-stream**:
  - Pulse ovf_clr together with a new drop → overflow stays 1.
  - Assert rst mid-burst → dout_valid goes 0 immediately. After release, no stale words emerge.
